// File: rtl/mem_responder.sv
// Command-driven word memory: zeroing sweep after reset, read/write by address, bump free-address allocator.
// Define MEM_RESPONDER_ERR_EN to add the err status output.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 10
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 68
`endif
`ifndef GET_CONTENTS
`define GET_CONTENTS 2'd0
`endif
`ifndef SET_CONTENTS
`define SET_CONTENTS 2'd1
`endif
`ifndef GET_FREE
`define GET_FREE 2'd2
`endif

// state   | meaning
// INIT    | after reset; optional zeroing sweep, one word per cycle
// IDLE    | is_ready high, waiting for execute
// READ    | load read_data from the latched address
// WRITE   | store latched write_data at the latched address
// FREE    | hand out the free pointer and advance it
// RELEASE | command done, wait for execute to drop
module mem_responder #(
   parameter int DEPTH          = 1024,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          power,
   input  logic [1:0]                    func,
   input  logic                          execute,
   input  logic [`MEMORY_ADDR_WIDTH-1:0] address,
   input  logic [`MEMORY_DATA_WIDTH-1:0] write_data,
   output logic [`MEMORY_DATA_WIDTH-1:0] read_data,
   output logic [`MEMORY_ADDR_WIDTH-1:0] free_addr,
   output logic                          is_ready,
   output logic [3:0]                    state
`ifdef MEM_RESPONDER_ERR_EN
   ,
   output logic                          err
`endif
);

   localparam int AW = `MEMORY_ADDR_WIDTH;
   localparam int DW = `MEMORY_DATA_WIDTH;
   localparam int PW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [3:0] {
      S_INIT    = 4'd0,
      S_IDLE    = 4'd1,
      S_READ    = 4'd2,
      S_WRITE   = 4'd3,
      S_FREE    = 4'd4,
      S_RELEASE = 4'd5
   } state_t;

   state_t          st;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [PW-1:0]   sweep_cnt;
   logic [PW-1:0]   free_ptr;
   logic [DW-1:0]   mem [DEPTH];

   logic            addr_ok;
   logic            pool_full;
   logic            mem_we;
   logic [IW-1:0]   mem_waddr;
   logic [DW-1:0]   mem_wdata;

   assign state     = st;
   assign addr_ok   = int'(addr_q) < DEPTH;
   assign pool_full = int'(free_ptr) >= DEPTH;

   // Memory has no reset; it is only cleared by the INIT sweep.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (rst && power) begin
         case (st)
            S_INIT: begin
               mem_we    = CLEAR_ON_RESET;
               mem_waddr = sweep_cnt[IW-1:0];
            end
            S_WRITE: begin
               mem_we    = addr_ok;
               mem_waddr = addr_q[IW-1:0];
               mem_wdata = wdata_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st        <= S_INIT;
         is_ready  <= 1'b0;
         read_data <= '0;
         free_addr <= '0;
         free_ptr  <= '0;
         sweep_cnt <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else if (power) begin
         case (st)
            S_INIT: begin
               if (!CLEAR_ON_RESET || int'(sweep_cnt) == DEPTH - 1) begin
                  st       <= S_IDLE;
                  is_ready <= 1'b1;
               end else begin
                  sweep_cnt <= sweep_cnt + PW'(1);
               end
            end
            S_IDLE: begin
               if (execute) begin
                  addr_q   <= address;
                  wdata_q  <= write_data;
                  is_ready <= 1'b0;
                  case (func)
                     `GET_CONTENTS: st <= S_READ;
                     `SET_CONTENTS: st <= S_WRITE;
                     `GET_FREE:     st <= S_FREE;
                     default:       st <= S_RELEASE;
                  endcase
               end
            end
            S_READ: begin
               read_data <= addr_ok ? mem[addr_q[IW-1:0]] : '0;
               st        <= S_RELEASE;
            end
            S_WRITE: st <= S_RELEASE;
            S_FREE: begin
               if (pool_full) begin
                  free_addr <= '1;
               end else begin
                  free_addr <= AW'(free_ptr);
                  free_ptr  <= free_ptr + PW'(1);
               end
               st <= S_RELEASE;
            end
            S_RELEASE: begin
               if (!execute) begin
                  st       <= S_IDLE;
                  is_ready <= 1'b1;
               end
            end
            default: begin
               st       <= S_IDLE;
               is_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef MEM_RESPONDER_ERR_EN
   // err reflects the most recent command; it becomes valid on entry to RELEASE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (power) begin
         case (st)
            S_IDLE:          if (execute) err <= 1'b0;
            S_READ, S_WRITE: err <= !addr_ok;
            S_FREE:          err <= pool_full;
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a 1024-word sweeping instance and a 4-word non-sweeping instance.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 10
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 68
`endif
`ifndef GET_CONTENTS
`define GET_CONTENTS 2'd0
`endif
`ifndef SET_CONTENTS
`define SET_CONTENTS 2'd1
`endif
`ifndef GET_FREE
`define GET_FREE 2'd2
`endif

module tb_mem_responder;
   localparam int AW = `MEMORY_ADDR_WIDTH;
   localparam int DW = `MEMORY_DATA_WIDTH;
   localparam logic [1:0] NOP = 2'd3;

   logic          clk = 1'b0;
   logic          rst, power, exec_b, exec_s, sel;
   logic [1:0]    func;
   logic [AW-1:0] address;
   logic [DW-1:0] write_data;
   logic [DW-1:0] rd_b, rd_s, rd_o;
   logic [AW-1:0] fa_b, fa_s, fa_o;
   logic          rdy_b, rdy_s, rdy_o;
   logic [3:0]    st_b, st_s, st_o;
`ifdef MEM_RESPONDER_ERR_EN
   logic          err_b, err_s, err_o;
   assign err_o = sel ? err_s : err_b;
`endif

   int checks = 0;
   int failures = 0;

   typedef struct { int kind; logic [DW-1:0] val; } exp_t;
   exp_t          exp_q[$];
   logic [DW-1:0] model_b[int];
   logic [DW-1:0] model_s[int];
   int            fp_b, fp_s;

   always #5 clk = ~clk;

   assign rd_o  = sel ? rd_s : rd_b;
   assign fa_o  = sel ? fa_s : fa_b;
   assign rdy_o = sel ? rdy_s : rdy_b;
   assign st_o  = sel ? st_s : st_b;

   mem_responder #(.DEPTH(1024), .CLEAR_ON_RESET(1'b1)) u_big (
      .clk(clk), .rst(rst), .power(power), .func(func), .execute(exec_b),
      .address(address), .write_data(write_data), .read_data(rd_b),
      .free_addr(fa_b), .is_ready(rdy_b), .state(st_b)
`ifdef MEM_RESPONDER_ERR_EN
      , .err(err_b)
`endif
   );

   mem_responder #(.DEPTH(4), .CLEAR_ON_RESET(1'b0)) u_small (
      .clk(clk), .rst(rst), .power(power), .func(func), .execute(exec_s),
      .address(address), .write_data(write_data), .read_data(rd_s),
      .free_addr(fa_s), .is_ready(rdy_s), .state(st_s)
`ifdef MEM_RESPONDER_ERR_EN
      , .err(err_s)
`endif
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_exec(input logic v);
      if (sel) exec_s = v;
      else     exec_b = v;
   endtask

   task automatic run_cmd(input string tag, input logic [1:0] f, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int hold);
      exp_t e;
      int   n, depth, fp;
      logic exp_err;
      depth   = sel ? 4 : 1024;
      fp      = sel ? fp_s : fp_b;
      exp_err = 1'b0;
      @(negedge clk);
      n = 0;
      while (rdy_o !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      check({tag, " ready"}, rdy_o, 1);
      if (f == `GET_CONTENTS) begin
         e.kind = 0;
         if (int'(a) >= depth) begin e.val = '0; exp_err = 1'b1; end
         else if (sel) e.val = model_s.exists(int'(a)) ? model_s[int'(a)] : '0;
         else          e.val = model_b.exists(int'(a)) ? model_b[int'(a)] : '0;
         exp_q.push_back(e);
      end else if (f == `SET_CONTENTS) begin
         if (int'(a) >= depth) exp_err = 1'b1;
         else if (sel) model_s[int'(a)] = d;
         else          model_b[int'(a)] = d;
      end else if (f == `GET_FREE) begin
         e.kind = 1;
         if (fp >= depth) begin e.val = {{(DW-AW){1'b0}}, {AW{1'b1}}}; exp_err = 1'b1; end
         else begin
            e.val = DW'(fp);
            if (sel) fp_s++; else fp_b++;
         end
         exp_q.push_back(e);
      end
      func = f; address = a; write_data = d;
      set_exec(1'b1);
      @(negedge clk);
      check({tag, " busy"}, rdy_o, 0);
`ifdef MEM_RESPONDER_ERR_EN
      check({tag, " err_clr"}, err_o, 0);
`endif
      func = f ^ 2'b01; address = ~a; write_data = ~d;
      n = 0;
      while (st_o !== 4'd5 && n < 10) begin @(negedge clk); n++; end
      check({tag, " release"}, st_o, 5);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, " hold"}, st_o, 5);
      end
      set_exec(1'b0);
      @(negedge clk);
      check({tag, " idle"}, rdy_o, 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.kind == 0) check({tag, " read_data"}, rd_o, e.val);
         else             check({tag, " free_addr"}, fa_o, e.val);
      end
`ifdef MEM_RESPONDER_ERR_EN
      check({tag, " err"}, err_o, exp_err);
`endif
   endtask

   // Releases reset at a negedge and returns the number of cycles until the big instance is ready;
   // optionally drops power for 10 cycles in the middle of the sweep.
   task automatic release_reset(input bit pause, output int n);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (rdy_b !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
         if (pause && n == 5)  power = 1'b0;
         if (pause && n == 15) power = 1'b1;
      end
   endtask

   initial begin
      int n;
      rst = 1'b0; power = 1'b1; exec_b = 1'b0; exec_s = 1'b0; sel = 1'b0;
      func = '0; address = '0; write_data = '0;
      fp_b = 0; fp_s = 0;
      repeat (3) @(negedge clk);
      check("rst state", st_b, 0);
      check("rst ready", rdy_b, 0);
      check("rst read_data", rd_b, 0);
      check("rst free_addr", fa_b, 0);
      check("rst small state", st_s, 0);

      release_reset(1'b0, n);
      check("init cycles", n, 1024);
      check("init idle state", st_b, 1);
      check("small ready", rdy_s, 1);

      run_cmd("free0", `GET_FREE, 10'd0, '0, 0);
      run_cmd("free1 held", `GET_FREE, 10'd0, '0, 5);
      run_cmd("free2", `GET_FREE, 10'd0, '0, 0);
      run_cmd("wr500", `SET_CONTENTS, 10'd500, {$urandom, $urandom, 4'h9}, 0);
      run_cmd("rd500", `GET_CONTENTS, 10'd500, '0, 0);
      run_cmd("wr1023 held", `SET_CONTENTS, 10'd1023, 68'hA_5555_AAAA_1234_5678, 5);
      run_cmd("rd1023", `GET_CONTENTS, 10'd1023, '0, 0);
      run_cmd("nop", NOP, 10'd3, 68'h1, 2);
      run_cmd("wr0", `SET_CONTENTS, 10'd0, 68'hDEADBEEF, 0);
      run_cmd("rd0", `GET_CONTENTS, 10'd0, '0, 0);

      power = 1'b0;
      func = `GET_FREE;
      exec_b = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("power freeze", st_b, 1);
      end
      exec_b = 1'b0;
      @(negedge clk);
      power = 1'b1;

      func = `GET_CONTENTS; address = 10'd500; exec_b = 1'b1;
      @(negedge clk);
      check("abort in read", st_b, 2);
      rst = 1'b0;
      #1;
      check("abort state", st_b, 0);
      check("abort ready", rdy_b, 0);
      check("abort read_data", rd_b, 0);
      exec_b = 1'b0;
      model_b.delete();
      fp_b = 0;
      fp_s = 0;
      release_reset(1'b1, n);
      check("init cycles paused", n, 1034);

      for (int i = 0; i < 1024; i++) run_cmd("sweep rd", `GET_CONTENTS, AW'(i), '0, 0);
      run_cmd("free after rst", `GET_FREE, 10'd0, '0, 0);

      sel = 1'b1;
      for (int i = 0; i < 5; i++) run_cmd("small free", `GET_FREE, 10'd0, '0, 0);
      run_cmd("small wr1", `SET_CONTENTS, 10'd1, 68'h7_0000_0000_0000_0042, 0);
      run_cmd("small wr5 oob", `SET_CONTENTS, 10'd5, 68'h3_1111_2222_3333_4444, 0);
      run_cmd("small rd1", `GET_CONTENTS, 10'd1, '0, 0);
      run_cmd("small rd9 oob", `GET_CONTENTS, 10'd9, '0, 0);
      run_cmd("small free full", `GET_FREE, 10'd0, '0, 0);
      run_cmd("small rd1 again", `GET_CONTENTS, 10'd1, '0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
